// File: rtl/tx_frame_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tx_frame_ctrl
// Sequencer for a framed serial transmitter built from an external
// parallel-to-serial shift register and a 4:1 line mux. A frame is sent as
// one start bit (0), DATA_BITS data bits and one stop bit (1). Each bit
// lasts CLKS_PER_BIT clock cycles.
//
// Parameters
//   DATA_BITS     data bits per frame (1..16), equal to the shift reg width
//   CLKS_PER_BIT  clk cycles per serial bit (2..256)
//
// Ports
//   clk           system clock, rising edge
//   n_rst         asynchronous active-low reset
//   start         frame request, only honoured in IDLE
//   clear         synchronous abort back to IDLE (wins over start)
//   load_enable   1-cycle pulse: shift register captures parallel data
//   shift_enable  1-cycle pulse: shift register advances one bit
//   frame_sel     line mux select: 00 idle, 01 start, 10 data, 11 stop
//   tx_active     high whenever the sequencer is not IDLE
//   tx_done       1-cycle pulse when a frame completes normally
//
// All outputs decode only the registered state, timer and bit counter, so
// start/clear never reach an output combinationally.
// ---------------------------------------------------------------------------
module tx_frame_ctrl #(
   parameter int DATA_BITS    = 8,
   parameter int CLKS_PER_BIT = 10
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       start,
   input  logic       clear,
   output logic       load_enable,
   output logic       shift_enable,
   output logic [1:0] frame_sel,
   output logic       tx_active,
   output logic       tx_done
);

   localparam int TIMER_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int CNT_W   = $clog2(DATA_BITS) + 1;

   localparam logic [TIMER_W-1:0] TICK_VAL = TIMER_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOAD      = 3'd1,
      START_BIT = 3'd2,
      DATA      = 3'd3,
      STOP      = 3'd4,
      DONE      = 3'd5
   } state_t;

   state_t             state_reg, state_next;
   logic [TIMER_W-1:0] timer_reg, timer_next;
   logic [CNT_W-1:0]   bit_cnt_reg, bit_cnt_next;
   logic               bit_tick;

   // Last cycle of the current serial bit.
   assign bit_tick = (timer_reg == TICK_VAL);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_reg   <= IDLE;
         timer_reg   <= '0;
         bit_cnt_reg <= '0;
      end else begin
         state_reg   <= state_next;
         timer_reg   <= timer_next;
         bit_cnt_reg <= bit_cnt_next;
      end
   end

   // Next-state logic. The timer defaults to zero so that it restarts on
   // every state change and rests at zero in IDLE, LOAD and DONE; it only
   // advances while a serial bit is in progress and has not yet ticked.
   always_comb begin
      state_next   = state_reg;
      timer_next   = '0;
      bit_cnt_next = bit_cnt_reg;

      if (clear) begin
         state_next   = IDLE;
         bit_cnt_next = '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  state_next = LOAD;
               end
            end
            LOAD: begin
               bit_cnt_next = '0;
               state_next   = START_BIT;
            end
            START_BIT: begin
               if (bit_tick) begin
                  state_next = DATA;
               end else begin
                  timer_next = timer_reg + 1'b1;
               end
            end
            DATA: begin
               if (bit_tick) begin
                  bit_cnt_next = bit_cnt_reg + 1'b1;
                  if (bit_cnt_reg == LAST_BIT) begin
                     state_next = STOP;
                  end
               end else begin
                  timer_next = timer_reg + 1'b1;
               end
            end
            STOP: begin
               if (bit_tick) begin
                  state_next = DONE;
               end else begin
                  timer_next = timer_reg + 1'b1;
               end
            end
            DONE: begin
               state_next = IDLE;
            end
            default: begin
               state_next   = IDLE;
               bit_cnt_next = '0;
            end
         endcase
      end
   end

   // Output decode. The shift pulse sits on the final cycle of each data
   // bit, so the last data bit is also shifted out before STOP begins.
   always_comb begin
      load_enable  = 1'b0;
      shift_enable = 1'b0;
      frame_sel    = 2'b00;
      tx_active    = (state_reg != IDLE);
      tx_done      = 1'b0;

      case (state_reg)
         LOAD:      load_enable = 1'b1;
         START_BIT: frame_sel   = 2'b01;
         DATA: begin
            frame_sel    = 2'b10;
            shift_enable = bit_tick;
         end
         STOP:      frame_sel   = 2'b11;
         DONE:      tx_done     = 1'b1;
         default:   frame_sel   = 2'b00;
      endcase
   end

endmodule

// File: tb/tb_tx_frame_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_tx_frame_ctrl
// Two instances share the stimulus: the default configuration (8 data bits,
// 10 clocks per bit) and the smallest one (1 data bit, 2 clocks per bit).
// A reference model tracks each frame as a plain position count since the
// LOAD cycle and derives the expected outputs arithmetically; expectations
// are queued per cycle and a separate checker pops and compares them.
// ---------------------------------------------------------------------------
module tb_tx_frame_ctrl;

   localparam int NI = 2;

   typedef struct packed {
      logic [1:0] fs;
      logic       act;
      logic       ld;
      logic       sh;
      logic       dn;
   } out_t;

   logic clk   = 1'b0;
   logic n_rst = 1'b0;
   logic start = 1'b0;
   logic clear = 1'b0;

   out_t dut_out [NI];

   generate
      for (genvar gi = 0; gi < NI; gi++) begin : g_dut
         logic       ld, sh, act, dn;
         logic [1:0] fs;
         tx_frame_ctrl #(
            .DATA_BITS   (gi == 0 ? 8 : 1),
            .CLKS_PER_BIT(gi == 0 ? 10 : 2)
         ) u_dut (
            .clk         (clk),
            .n_rst       (n_rst),
            .start       (start),
            .clear       (clear),
            .load_enable (ld),
            .shift_enable(sh),
            .frame_sel   (fs),
            .tx_active   (act),
            .tx_done     (dn)
         );
         assign dut_out[gi] = {fs, act, ld, sh, dn};
      end
   endgenerate

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic int db_of(input int k);
      return (k == 0) ? 8 : 1;
   endfunction

   function automatic int cpb_of(input int k);
      return (k == 0) ? 10 : 2;
   endfunction

   // Position of the DONE cycle: LOAD(1) + start bit + data bits + stop bit.
   function automatic int last_p(input int k);
      return cpb_of(k) * (db_of(k) + 2) + 1;
   endfunction

   function automatic int next_p(input int k, input int p, input logic s, input logic c);
      if (c)              return -1;
      if (p < 0)          return s ? 0 : -1;
      if (p >= last_p(k)) return -1;
      return p + 1;
   endfunction

   function automatic out_t expect_out(input int k, input int p);
      out_t o;
      int   cpb;
      int   db;
      o   = '0;
      cpb = cpb_of(k);
      db  = db_of(k);
      if (p < 0) return o;
      o.act = 1'b1;
      if (p == 0) begin
         o.ld = 1'b1;
      end else if (p <= cpb) begin
         o.fs = 2'b01;
      end else if (p <= cpb * (db + 1)) begin
         o.fs = 2'b10;
         o.sh = (((p - cpb) % cpb) == 0);
      end else if (p <= cpb * (db + 2)) begin
         o.fs = 2'b11;
      end else begin
         o.dn = 1'b1;
      end
      return o;
   endfunction

   int   pos [NI] = '{-1, -1};
   out_t exp_q [NI][$];

   initial begin
      forever begin
         @(posedge clk or negedge n_rst);
         for (int k = 0; k < NI; k++) begin
            if (!n_rst) begin
               pos[k] = -1;
               exp_q[k].delete();
               exp_q[k].push_back('0);
            end else begin
               pos[k] = next_p(k, pos[k], start, clear);
               exp_q[k].push_back(expect_out(k, pos[k]));
            end
         end
      end
   end

   // ---------------- checker ----------------
   int   checks     = 0;
   int   failures   = 0;
   int   exp_done [NI] = '{0, 0};
   int   obs_done [NI] = '{0, 0};
   int   probe_id   = 0;
   int   probe_seen = 0;
   out_t probe_val [NI];
   int   timeouts   = 0;
   bit   final_req  = 1'b0;
   bit   final_done = 1'b0;

   initial begin
      out_t e;
      forever begin
         @(negedge clk);
         for (int k = 0; k < NI; k++) begin
            if (exp_q[k].size() > 0) begin
               e = exp_q[k].pop_front();
               if (e.dn) exp_done[k]++;
               if (dut_out[k].dn) obs_done[k]++;
               checks++;
               if (dut_out[k] !== e) begin
                  failures++;
                  $display("FAIL cycle_out[%0d] t=%0t got fs=%b act=%b ld=%b sh=%b dn=%b want fs=%b act=%b ld=%b sh=%b dn=%b",
                           k, $time, dut_out[k].fs, dut_out[k].act, dut_out[k].ld,
                           dut_out[k].sh, dut_out[k].dn, e.fs, e.act, e.ld, e.sh, e.dn);
               end
               checks++;
               if (dut_out[k].ld && dut_out[k].sh) begin
                  failures++;
                  $display("FAIL load_shift_overlap[%0d] t=%0t got ld=1 sh=1 want not both", k, $time);
               end
            end
         end
         // Snapshots taken by the stimulus while n_rst is low must be all zero.
         if (probe_id != probe_seen) begin
            probe_seen = probe_id;
            for (int k = 0; k < NI; k++) begin
               checks++;
               if (probe_val[k] !== out_t'(0)) begin
                  failures++;
                  $display("FAIL async_reset_outputs[%0d] probe=%0d got %b want 000000",
                           k, probe_seen, probe_val[k]);
               end
            end
         end
         if (final_req && !final_done) begin
            for (int k = 0; k < NI; k++) begin
               checks++;
               if (obs_done[k] != exp_done[k]) begin
                  failures++;
                  $display("FAIL done_count[%0d] got %0d want %0d", k, obs_done[k], exp_done[k]);
               end
            end
            checks++;
            if (timeouts != 0) begin
               failures++;
               $display("FAIL wait_timeouts got %0d want 0", timeouts);
            end
            final_done = 1'b1;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_sel(input logic [1:0] v, input int budget);
      int n;
      n = 0;
      @(negedge clk);
      while (dut_out[0].fs !== v && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) timeouts++;
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      @(negedge clk);
      while (dut_out[0].dn !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) timeouts++;
   endtask

   task automatic take_probe();
      for (int k = 0; k < NI; k++) probe_val[k] = dut_out[k];
      probe_id++;
   endtask

   initial begin
      int n;
      // Reset for two cycles, check outputs while held.
      n_rst = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      take_probe();
      #1;
      n_rst = 1'b1;
      tick(3);

      // Single frame.
      start = 1'b1; tick(1); start = 1'b0;
      tick(110);

      // Busy: start during DATA and during DONE must be ignored.
      start = 1'b1; tick(1); start = 1'b0;
      tick(40);
      start = 1'b1; tick(1); start = 1'b0;
      wait_done(200);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(20);

      // Back-to-back with start held high.
      start = 1'b1; tick(230); start = 1'b0;
      tick(110);

      // Abort during the third data bit, then a fresh frame.
      start = 1'b1; tick(1); start = 1'b0;
      tick(34);
      clear = 1'b1; tick(1); clear = 1'b0;
      tick(5);
      start = 1'b1; tick(1); start = 1'b0;
      tick(110);

      // clear beats start in IDLE; clear in LOAD kills the frame.
      start = 1'b1; clear = 1'b1; tick(1);
      clear = 1'b0; tick(1);
      start = 1'b0; clear = 1'b1; tick(1);
      clear = 1'b0;
      tick(10);

      // Asynchronous reset between edges during STOP.
      start = 1'b1; tick(1); start = 1'b0;
      wait_sel(2'b11, 200);
      tick(3);
      #1;
      n_rst = 1'b0;
      #1;
      take_probe();
      tick(2);
      n_rst = 1'b1;
      tick(20);

      // Random traffic.
      for (int i = 0; i < 4000; i++) begin
         start = ($urandom_range(0, 19) == 0);
         clear = ($urandom_range(0, 149) == 0);
         tick(1);
      end
      start = 1'b0;
      clear = 1'b0;
      tick(120);

      final_req = 1'b1;
      n = 0;
      while (!final_done && n < 10) begin
         @(posedge clk);
         n++;
      end
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
